// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC sequencing, word-addressed instruction memory with
// synchronous read, one-bubble redirects, loader write port and a sticky fetch fault.
module instr_fetch #(
   parameter int unsigned IMEM_DEPTH = 256,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] NOP        = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        load_we,
   input  logic [31:0] load_addr,
   input  logic [31:0] load_data,
   output logic [31:0] instruction,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        instr_valid,
   output logic        fetch_fault
);

   localparam int unsigned AW = $clog2(IMEM_DEPTH);

   typedef enum logic [1:0] {StIdle, StRun, StFault} state_e;

   state_e      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_q, pc_d;
   logic        valid_q, valid_d;
   logic        fault_q, fault_d;

   logic [31:0] mem [IMEM_DEPTH];

   logic [AW-1:0] fetch_idx;
   logic [AW-1:0] load_idx;
   logic          fetch_legal;
   logic          load_legal;
   logic          unused_load_bits;

   assign fetch_idx   = fetch_pc_q[AW+1:2];
   assign load_idx    = load_addr[AW+1:2];
   // Word index must be in range and the byte address word-aligned.
   assign fetch_legal = (fetch_pc_q[1:0] == 2'b00) && (fetch_pc_q[31:AW+2] == '0);
   assign load_legal  = (load_addr[31:AW+2] == '0);
   // Loader byte offset is ignored by design.
   assign unused_load_bits = ^load_addr[1:0];

   // Loader writes memory on any edge, independent of en, state and reset.
   always_ff @(posedge clk) begin
      if (load_we && load_legal) begin
         mem[load_idx] <= load_data;
      end
   end

   // Fetch state registers, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         fetch_pc_q <= RESET_PC;
         instr_q    <= NOP;
         pc_q       <= RESET_PC;
         valid_q    <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         instr_q    <= instr_d;
         pc_q       <= pc_d;
         valid_q    <= valid_d;
         fault_q    <= fault_d;
      end
   end

   // Next-state: sequential fetch, redirect bubble, or fault; everything holds otherwise.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      instr_d    = instr_q;
      pc_d       = pc_q;
      valid_d    = valid_q;
      fault_d    = fault_q;
      if (en) begin
         unique case (state_q)
            StIdle, StRun: begin
               if (state_q == StRun && redirect) begin
                  // Word read this edge is wrong-path; drop it and emit a bubble.
                  instr_d    = NOP;
                  valid_d    = 1'b0;
                  fetch_pc_d = redirect_pc;
               end else if (fetch_legal) begin
                  instr_d    = mem[fetch_idx];
                  pc_d       = fetch_pc_q;
                  valid_d    = 1'b1;
                  fetch_pc_d = fetch_pc_q + 32'd4;
                  state_d    = StRun;
               end else begin
                  instr_d = NOP;
                  pc_d    = fetch_pc_q;
                  valid_d = 1'b0;
                  fault_d = 1'b1;
                  state_d = StFault;
               end
            end
            default: begin
               // StFault absorbs until reset.
            end
         endcase
      end
   end

   assign instruction = instr_q;
   assign pc          = pc_q;
   assign pc_plus4    = pc_q + 32'd4;
   assign instr_valid = valid_q;
   assign fetch_fault = fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch.
module tb_instr_fetch;

   localparam logic [31:0] NOP_W = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        load_we;
   logic [31:0] load_addr;
   logic [31:0] load_data;
   logic [31:0] instruction;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        instr_valid;
   logic        fetch_fault;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] exp_mem [256];

   instr_fetch #(
      .IMEM_DEPTH(256),
      .RESET_PC  (32'h0000_0000),
      .NOP       (NOP_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .load_we    (load_we),
      .load_addr  (load_addr),
      .load_data  (load_data),
      .instruction(instruction),
      .pc         (pc),
      .pc_plus4   (pc_plus4),
      .instr_valid(instr_valid),
      .fetch_fault(fetch_fault)
   );

   always #5 clk = ~clk;

   // One rising edge; sample 1 ns later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_word(input logic [31:0] addr, input logic [31:0] data);
      load_we   = 1'b1;
      load_addr = addr;
      load_data = data;
      step();
      load_we   = 1'b0;
   endtask

   // Asynchronous reset pulse: outputs must clear before any clock edge.
   task automatic do_reset(input string tag);
      rst = 1'b1;
      #1;
      vectors++;
      if ({instruction, pc, pc_plus4, instr_valid, fetch_fault} !==
          {NOP_W, 32'h0, 32'h4, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL %s: instr=%h pc=%h pc4=%h v=%b f=%b, want %h 0 4 0 0", tag,
                  instruction, pc, pc_plus4, instr_valid, fetch_fault, NOP_W);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      do_reset("reset");
   endtask

   // Sequential fetch of words 0..2 with en held high.
   task automatic test_sequence();
      en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         vectors++;
         if ({instruction, pc, pc_plus4, instr_valid, fetch_fault} !==
             {exp_mem[i], 32'(4 * i), 32'(4 * i + 4), 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL seq%0d: instr=%h pc=%h pc4=%h v=%b f=%b, want %h %h %h 1 0", i,
                     instruction, pc, pc_plus4, instr_valid, fetch_fault, exp_mem[i],
                     32'(4 * i), 32'(4 * i + 4));
         end
      end
   endtask

   // Three stalled cycles at pc=8 with a redirect pulse, then resume at pc=12.
   task automatic test_stall();
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         redirect    = (i == 1);
         redirect_pc = 32'h40;
         step();
         vectors++;
         if ({instruction, pc, instr_valid} !== {exp_mem[2], 32'h8, 1'b1}) begin
            miscompares++;
            $display("FAIL stall%0d: instr=%h pc=%h v=%b, want %h 8 1", i, instruction, pc,
                     instr_valid, exp_mem[2]);
         end
      end
      redirect = 1'b0;
      en = 1'b1;
      step();
      vectors++;
      if ({instruction, pc, instr_valid} !== {exp_mem[3], 32'hC, 1'b1}) begin
         miscompares++;
         $display("FAIL stall_resume: instr=%h pc=%h v=%b, want %h c 1", instruction, pc,
                  instr_valid, exp_mem[3]);
      end
   endtask

   // Redirect at pc=4 to 0x20: one bubble, then word 8.
   task automatic test_redirect();
      do_reset("redirect_rst");
      en = 1'b1;
      step();
      step();
      redirect    = 1'b1;
      redirect_pc = 32'h20;
      step();
      redirect = 1'b0;
      vectors++;
      if ({instruction, pc, pc_plus4, instr_valid} !== {NOP_W, 32'h4, 32'h8, 1'b0}) begin
         miscompares++;
         $display("FAIL redir_bubble: instr=%h pc=%h pc4=%h v=%b, want %h 4 8 0", instruction,
                  pc, pc_plus4, instr_valid, NOP_W);
      end
      step();
      vectors++;
      if ({instruction, pc, instr_valid} !== {exp_mem[8], 32'h20, 1'b1}) begin
         miscompares++;
         $display("FAIL redir_target: instr=%h pc=%h v=%b, want %h 20 1", instruction, pc,
                  instr_valid, exp_mem[8]);
      end
      step();
      vectors++;
      if ({instruction, pc, instr_valid} !== {exp_mem[9], 32'h24, 1'b1}) begin
         miscompares++;
         $display("FAIL redir_next: instr=%h pc=%h v=%b, want %h 24 1", instruction, pc,
                  instr_valid, exp_mem[9]);
      end
   endtask

   // Write to word 2 on the edge that fetches word 2 returns old data; then new data.
   task automatic test_loader();
      logic [31:0] old_w;
      do_reset("loader_rst");
      en = 1'b1;
      step();
      step();
      old_w = exp_mem[2];
      load_word(32'h8, 32'hDEAD_BEEF);
      exp_mem[2] = 32'hDEAD_BEEF;
      vectors++;
      if ({instruction, pc, instr_valid} !== {old_w, 32'h8, 1'b1}) begin
         miscompares++;
         $display("FAIL load_rbw: instr=%h pc=%h v=%b, want %h 8 1", instruction, pc,
                  instr_valid, old_w);
      end
      // Out-of-range write must be dropped (word 0 would be the alias).
      en = 1'b0;
      load_word(32'h400, 32'h5555_5555);
      load_word(32'h7FC, 32'h6666_6666);
      do_reset("loader_rst2");
      en = 1'b1;
      step();
      step();
      step();
      vectors++;
      if ({instruction, pc} !== {exp_mem[2], 32'h8}) begin
         miscompares++;
         $display("FAIL load_new: instr=%h pc=%h, want %h 8", instruction, pc, exp_mem[2]);
      end
   endtask

   // Full sweep of memory then fault one past the last word.
   task automatic test_fault_range();
      do_reset("range_rst");
      en = 1'b1;
      for (int i = 0; i < 256; i++) begin
         step();
         vectors++;
         if ({instruction, pc, instr_valid, fetch_fault} !==
             {exp_mem[i], 32'(4 * i), 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL sweep%0d: instr=%h pc=%h v=%b f=%b, want %h %h 1 0", i,
                     instruction, pc, instr_valid, fetch_fault, exp_mem[i], 32'(4 * i));
         end
      end
      step();
      vectors++;
      if ({instruction, pc, instr_valid, fetch_fault} !== {NOP_W, 32'h400, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL range_fault: instr=%h pc=%h v=%b f=%b, want %h 400 0 1", instruction,
                  pc, instr_valid, fetch_fault, NOP_W);
      end
   endtask

   // Redirect to a misaligned target; fault is sticky until an async reset.
   task automatic test_fault_misaligned();
      do_reset("misal_rst");
      en          = 1'b1;
      redirect    = 1'b1;  // ignored in IDLE
      redirect_pc = 32'h40;
      step();
      vectors++;
      if ({instruction, pc, instr_valid} !== {exp_mem[0], 32'h0, 1'b1}) begin
         miscompares++;
         $display("FAIL idle_redir: instr=%h pc=%h v=%b, want %h 0 1", instruction, pc,
                  instr_valid, exp_mem[0]);
      end
      redirect_pc = 32'h22;
      step();
      redirect = 1'b0;
      vectors++;
      if ({instruction, pc, instr_valid, fetch_fault} !== {NOP_W, 32'h0, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL misal_bubble: instr=%h pc=%h v=%b f=%b, want %h 0 0 0", instruction,
                  pc, instr_valid, fetch_fault, NOP_W);
      end
      for (int i = 0; i < 7; i++) begin
         redirect    = (i == 6);
         redirect_pc = 32'h0;
         load_we     = (i == 3);
         load_addr   = 32'h0;
         load_data   = exp_mem[0];
         step();
         vectors++;
         if ({instruction, pc, instr_valid, fetch_fault} !== {NOP_W, 32'h22, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL misal_hold%0d: instr=%h pc=%h v=%b f=%b, want %h 22 0 1", i,
                     instruction, pc, instr_valid, fetch_fault, NOP_W);
         end
      end
      redirect = 1'b0;
      load_we  = 1'b0;
      do_reset("fault_async_rst");
   endtask

   initial begin
      rst         = 1'b1;
      en          = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      load_we     = 1'b0;
      load_addr   = 32'h0;
      load_data   = 32'h0;
      exp_mem[0] = 32'h0050_0093;
      exp_mem[1] = 32'h00A0_0113;
      exp_mem[2] = 32'h0020_81B3;
      exp_mem[3] = 32'h0000_006F;
      for (int i = 4; i < 256; i++) exp_mem[i] = 32'hA000_0000 | 32'(i);
      #1;
      for (int i = 0; i < 256; i++) load_word(32'(4 * i), exp_mem[i]);
      test_reset();
      test_sequence();
      test_stall();
      test_redirect();
      test_loader();
      test_fault_range();
      test_fault_misaligned();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage that sits directly upstream of `single_cycle` and drives its `instruction` input. Holds the program counter and a word-addressed instruction memory with synchronous read. Accepts taken-branch/jump redirects from the core, and has a loader write port so benches can place a program before releasing `en`. Produces a registered instruction, its PC, and a valid flag; a fetch from an illegal address raises a sticky fault.

## Interface
- `IMEM_DEPTH`, 256: instruction memory size in 32-bit words. Power of two, at least 4.
- `RESET_PC`, 32'h0000_0000: PC loaded on reset.
- `NOP`, 32'h0000_0013: `addi x0,x0,0`, driven whenever no valid instruction is presented.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `en`  in  1: advance enable. While low, all fetch state holds.
- `redirect`  in  1: the instruction currently presented was a taken branch or jump.
- `redirect_pc`  in  32: byte target for `redirect`.
- `load_we`  in  1: loader write strobe.
- `load_addr`  in  32: loader byte address. Bits [1:0] are ignored.
- `load_data`  in  32: loader write data.
- `instruction`  out  32: instruction presented to the core (registered).
- `pc`  out  32: byte address of `instruction` (registered).
- `pc_plus4`  out  32: `pc + 4`, combinational, mod 2^32.
- `instr_valid`  out  1: `instruction` is a real, architecturally valid fetch.
- `fetch_fault`  out  1: sticky illegal-fetch flag.

## Operation
- Internal registers:
  - `fetch_pc`: address being read from memory.
  - Output registers: `instruction`, `pc`, `instr_valid`, `fetch_fault`.
  - FSM with states IDLE, RUN, FAULT.
- Reset (async, immediate) forces:
  - `fetch_pc=RESET_PC`, `pc=RESET_PC`, `pc_plus4=RESET_PC+4`
  - `instruction=NOP`, `instr_valid=0`, `fetch_fault=0`
  - state IDLE.
  - Memory contents are not reset.
- Fetch edge: a rising edge with `en=1` in IDLE or RUN.
  - Legal: `fetch_pc[1:0]==0` and `fetch_pc[31:2] < IMEM_DEPTH`. Then:
    - `instruction <= mem[fetch_pc[31:2]]`
    - `pc <= fetch_pc`
    - `instr_valid <= 1`
    - `fetch_pc <= fetch_pc+4` (wraps at 2^32)
    - state becomes RUN.
  - Illegal: `instruction <= NOP`, `instr_valid <= 0`, `fetch_fault <= 1`, `pc <= fetch_pc`, state becomes FAULT.
- Redirect: sampled only on an edge with `en=1` and state RUN.
  - The memory word read at that edge is wrong-path and is discarded: `instruction <= NOP`, `instr_valid <= 0`, `pc` holds, `fetch_pc <= redirect_pc`.
  - Result is exactly one bubble per taken redirect.
  - Redirect takes priority over the fault check of the discarded wrong-path address.
  - A misaligned or out-of-range `redirect_pc` faults on the following fetch edge.
- IDLE: `redirect` is ignored.
- FAULT: absorbing until reset. `en`, `redirect` and the loader do not change the outputs. The loader still writes memory.
- `en=0`: every fetch register holds, and `redirect` is ignored.
- Loader:
  - On any edge with `load_we=1`, writes `mem[load_addr[31:2]] <= load_data`, regardless of `en` or state.
  - Writes with `load_addr[31:2] >= IMEM_DEPTH` are dropped.
  - A write and a fetch to the same word on the same edge: the fetch returns the old data (read-before-write).

## Timing
- Fetch latency is 1 cycle: the word at `fetch_pc` appears on `instruction` after the fetch edge.
- First valid instruction appears after the first `en=1` edge following reset deassertion.
- Sequential throughput is one instruction per `en=1` cycle.
- A taken redirect costs 1 cycle: the redirect edge outputs a NOP bubble, and the target instruction is valid after the next `en=1` edge.
- `pc_plus4` tracks `pc` in the same cycle, with no added latency.
- `rst` asserted mid-run clears outputs asynchronously, without waiting for a clock edge. Deassertion is expected to meet recovery timing relative to `clk`.

## Test plan
- Reset and sequence:
  - Stimulus: load words 0..3 = 0x00500093, 0x00A00113, 0x002081B3, 0x0000006F; release `rst`; hold `en=1` for 4 cycles.
  - Required: `pc` steps 0,4,8,12; `instruction` matches the loaded words in order; `instr_valid` is 1 from the first edge; `pc_plus4` = `pc`+4.
- Stall:
  - Stimulus: `en=0` for 3 cycles at `pc=8`, with `redirect=1` pulsed during the stall.
  - Required: `instruction`, `pc` and `instr_valid` are frozen; the redirect has no effect; fetch resumes at `pc=12`.
- Redirect:
  - Stimulus: while `pc=4`, assert `redirect=1` with `redirect_pc=0x20` for one `en=1` edge.
  - Required: the next output is NOP with `instr_valid=0` and `pc=4`; the following edge gives `pc=0x20` and `instruction=mem[8]`.
- Fault, misaligned:
  - Stimulus: redirect to 0x22.
  - Required: bubble, then `fetch_fault=1`, `instr_valid=0`, `instruction=NOP`, `pc=0x22`; the outputs stay so through 5 further `en=1` cycles and a redirect to 0x0.
  - Stimulus: then assert `rst`.
  - Required: `fetch_fault=0` immediately, without waiting for a clock edge.
- Fault, out of range:
  - Stimulus: `IMEM_DEPTH=256`; sequential fetch runs past word 255.
  - Required: `pc=0x3FC` is valid; the next edge faults with `pc=0x400`.
- Loader:
  - Stimulus: a load to word 2 on the same edge that fetches word 2.
  - Required: the old value is fetched.
  - Stimulus: `load_addr=0x400` with `IMEM_DEPTH=256`.
  - Required: the write is dropped and words 0..255 are unchanged.
